pe_weight_packer: RTL

- Producer side of the PE weight interface.
- Accepts a serial stream of 8-bit kernel weights and bit-plane-transposes them into one 200-bit PE weight word. The word layout matches PE_weight_t from diff_core_pkg.
- Presents the word to the PE matrix over a valid/ready handshake.
- Double-buffered: the next kernel fills while the current word waits for the PE.

---
 rtl/pe_weight_packer_if.sv | 36 +++
 rtl/pe_weight_packer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pe_weight_packer_if.sv
// Weight-stream and PE-word bundle for pe_weight_packer.
// The packer is the master; out_zero exists only when WPACK_ZERO_FLAG_EN is defined.
interface pe_weight_packer_if;
   logic [2:0]   cfg_mode;
   logic [7:0]   w_data;
   logic         w_valid;
   logic         w_last;
   logic         w_ready;
   logic [199:0] out_weight;
   logic         out_valid;
   logic         out_ready;
   logic         err_len;
   logic         fill_state;
   logic [4:0]   fill_idx;
`ifdef WPACK_ZERO_FLAG_EN
   logic         out_zero;
`endif

   // Both streams: a beat moves on a rising clk edge where valid && ready;
   // the sender holds its data stable while valid is high and ready is low.
   modport master (
      input  cfg_mode, w_data, w_valid, w_last, out_ready,
      output w_ready, out_weight, out_valid, err_len, fill_state, fill_idx
`ifdef WPACK_ZERO_FLAG_EN
      , output out_zero
`endif
   );

   modport slave (
      output cfg_mode, w_data, w_valid, w_last, out_ready,
      input  w_ready, out_weight, out_valid, err_len, fill_state, fill_idx
`ifdef WPACK_ZERO_FLAG_EN
      , input out_zero
`endif
   );
endinterface

// File: rtl/pe_weight_packer.sv
// Bit-plane transposes a serial kernel of 8-bit weights into one 200-bit PE word,
// double-buffered behind a valid/ready output. Optional zero flag: WPACK_ZERO_FLAG_EN.
module pe_weight_packer #(
   parameter int W_BITS    = 8,
   parameter int OUT_WIDTH = 200
) (
   input logic clk,
   input logic rst,
   pe_weight_packer_if.master bus
);

   typedef enum logic {FILL = 1'b0, PEND = 1'b1} fill_state_t;

   fill_state_t          state;
   logic [4:0]           k;
   logic [2:0]           mode_q;
   logic [2:0]           mode_eff;
   logic [4:0]           k_end;
   logic [OUT_WIDTH-1:0] fill_q;
   logic [OUT_WIDTH-1:0] fill_next;
   logic [OUT_WIDTH-1:0] out_q;
   logic                 out_valid_q;
   logic                 err_q;
   logic                 w_ready;
   logic                 xfer;
   logic                 at_end;
   logic                 complete;
   logic                 slot_free;
   logic [7:0]           base;
   logic [7:0]           step;
   logic [7:0]           col;
   logic [W_BITS-1:0]    w_in;

   assign w_in      = bus.w_data;
   // The kernel's mode is only valid on its first weight; later beats use the latched copy.
   assign mode_eff  = (k == 5'd0) ? bus.cfg_mode : mode_q;
   assign k_end     = (mode_eff == 3'd4) ? 5'd8 : 5'd24;
   assign at_end    = (k == k_end);
   assign w_ready   = !rst && (state == FILL);
   assign xfer      = bus.w_valid && w_ready;
   assign complete  = xfer && (at_end || bus.w_last);
   assign slot_free = !out_valid_q || bus.out_ready;

   always_comb begin
      base = 8'd0;
      step = 8'd4;
      col  = 8'd0;
      if (k < 5'd9) begin
         base = 8'd128;
         step = 8'd9;
         col  = {3'b000, k};
      end else if (k < 5'd15) begin
         base = 8'd80;
         step = 8'd6;
         col  = {3'b000, k} - 8'd9;
      end else if (k < 5'd21) begin
         base = 8'd32;
         step = 8'd6;
         col  = {3'b000, k} - 8'd15;
      end else begin
         base = 8'd0;
         step = 8'd4;
         col  = {3'b000, k} - 8'd21;
      end
      fill_next = (k == 5'd0) ? '0 : fill_q;
      for (int b = 0; b < W_BITS; b++) begin
         fill_next[base + 8'(b) * step + col] = w_in[b];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         k           <= 5'd0;
         mode_q      <= 3'd0;
         fill_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         if (xfer) begin
            if (k == 5'd0) mode_q <= bus.cfg_mode;
            if (bus.w_last != at_end) err_q <= 1'b1;
            k <= complete ? 5'd0 : k + 5'd1;
            if (complete && slot_free) begin
               out_q       <= fill_next;
               out_valid_q <= 1'b1;
            end else begin
               fill_q <= fill_next;
            end
            if (complete && !slot_free) state <= PEND;
         end
         // A finished kernel parked in fill_q moves as soon as the output slot empties.
         if (state == PEND && slot_free) begin
            out_q       <= fill_q;
            out_valid_q <= 1'b1;
            state       <= FILL;
         end
      end
   end

`ifdef WPACK_ZERO_FLAG_EN
   logic zero_q;
   logic zero_next;
   logic out_zero_q;

   assign zero_next = ((k == 5'd0) || zero_q) && (w_in == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q     <= 1'b0;
         out_zero_q <= 1'b0;
      end else begin
         if (xfer) zero_q <= zero_next;
         if (complete && slot_free) out_zero_q <= zero_next;
         else if (state == PEND && slot_free) out_zero_q <= zero_q;
      end
   end

   assign bus.out_zero = out_zero_q;
`endif

   assign bus.w_ready    = w_ready;
   assign bus.out_weight = out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.err_len    = err_q;
   assign bus.fill_state = state;
   assign bus.fill_idx   = k;

endmodule
